// File: rtl/board_status_uart_if.sv
// -----------------------------------------------------------------------------
// board_status_uart_if
// Groups the status inputs and UART-side outputs of board_status_uart.
//   i_sd_init_done : TF-card init success flag (async to the reporter)
//   i_sdram_error  : SDRAM test error flag (async to the reporter)
//   i_key[3:0]     : raw user keys, active-low (async to the reporter)
//   o_uart_tx      : 8N1 serial line, idle high
//   o_busy         : high while a status frame is on the line
//   o_frame_done   : one-cycle pulse in the first idle cycle after a frame
// Modports: master drives the status flags (board / bench side),
//           slave is the reporter itself.
// -----------------------------------------------------------------------------
interface board_status_uart_if;
  logic       i_sd_init_done;
  logic       i_sdram_error;
  logic [3:0] i_key;
  logic       o_uart_tx;
  logic       o_busy;
  logic       o_frame_done;

  modport master (
    output i_sd_init_done, i_sdram_error, i_key,
    input  o_uart_tx, o_busy, o_frame_done
  );

  modport slave (
    input  i_sd_init_done, i_sdram_error, i_key,
    output o_uart_tx, o_busy, o_frame_done
  );
endinterface

// File: rtl/board_status_uart.sv
// -----------------------------------------------------------------------------
// board_status_uart
// Board self-test status reporter. Synchronizes the TF-card / SDRAM status
// flags and the four user keys, and transmits a 19-byte ASCII line
//   "SD:<d0> RAM:<d1> K:<k3><k2><k1><k0>\r\n"
// on an 8N1 UART. A line is sent after reset, every REPORT_PERIOD cycles,
// and whenever the sd/ram flags change (key changes alone never trigger).
// Ports:
//   i_clk_25m : the single clock
//   i_rst     : synchronous active-high reset
//   st        : board_status_uart_if.slave (status inputs, UART outputs)
// Parameters: CLK_FREQ, BAUD (CLKS_PER_BIT = CLK_FREQ/BAUD, must be >= 2),
//             REPORT_PERIOD (cycles between periodic frame starts).
// -----------------------------------------------------------------------------
module board_status_uart #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int BAUD          = 115200,
  parameter int REPORT_PERIOD = 25_000_000
) (
  input  logic           i_clk_25m,
  input  logic           i_rst,
  board_status_uart_if.slave st
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_PERIOD - 1);
  localparam logic [4:0]    BYTE_LAST  = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Status vector layout: {key[3:0], ram, sd}
  logic [5:0] raw;
  logic [5:0] meta_q;
  logic [5:0] sync_q;
  logic [1:0] prev_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [4:0]      byte_q, byte_d;
  logic [5:0]      snap_q, snap_d;
  logic            pending_q, pending_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            baud_tick;
  logic            start_frame;
  logic            change_evt;
  logic            period_hit;
  logic [7:0]      cur_byte;

  assign raw = {st.i_key, st.i_sdram_error, st.i_sd_init_done};

  // Synchronizers carry no reset: they only track the pins, and leaving them
  // running through reset means the boot snapshot already holds real values
  // and no spurious change event fires right after release.
  always_ff @(posedge i_clk_25m) begin
    meta_q <= raw;
    sync_q <= meta_q;
    prev_q <= sync_q[1:0];
  end

  assign change_evt = |(sync_q[1:0] ^ prev_q);

  // Frame text, built from the snapshot taken at frame start.
  function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [5:0] snap);
    logic [7:0] b;
    case (idx)
      5'd0:    b = "S";
      5'd1:    b = "D";
      5'd2:    b = ":";
      5'd3:    b = {7'b0011000, snap[0]};
      5'd4:    b = " ";
      5'd5:    b = "R";
      5'd6:    b = "A";
      5'd7:    b = "M";
      5'd8:    b = ":";
      5'd9:    b = {7'b0011000, snap[1]};
      5'd10:   b = " ";
      5'd11:   b = "K";
      5'd12:   b = ":";
      // Keys are active-low; a pressed key reads as '1'.
      5'd13:   b = {7'b0011000, ~snap[5]};
      5'd14:   b = {7'b0011000, ~snap[4]};
      5'd15:   b = {7'b0011000, ~snap[3]};
      5'd16:   b = {7'b0011000, ~snap[2]};
      5'd17:   b = 8'h0D;
      5'd18:   b = 8'h0A;
      default: b = 8'h20;
    endcase
    return b;
  endfunction

  assign cur_byte  = frame_byte(byte_q, snap_q);
  assign baud_tick = (baud_q == BIT_LAST);

  // FSM next state
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    snap_d      = snap_q;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d     = ST_START;
          baud_d      = '0;
          bit_d       = '0;
          byte_d      = '0;
          snap_d      = sync_q;
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = ST_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the
  // state register by one cycle; busy therefore covers exactly the time the
  // FSM spends outside IDLE.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte[bit_q];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE);
    // First idle cycle after a frame: FSM already idle, busy still high.
    done_d = (state_q == ST_IDLE) && busy_q;
  end

  // Period timer and pending flag. The hit is taken on the value the timer
  // is about to reach, so the periodic start bit lands exactly
  // REPORT_PERIOD cycles after the previous one. A trigger wins over the
  // clear in the consuming cycle so it is never lost.
  always_comb begin
    if (start_frame) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    period_hit = (timer_d == TIMER_LAST);
    pending_d  = (pending_q & ~start_frame) | change_evt | period_hit;
  end

  always_ff @(posedge i_clk_25m) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      snap_q    <= '0;
      pending_q <= 1'b1;
      timer_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign st.o_uart_tx    = tx_q;
  assign st.o_busy       = busy_q;
  assign st.o_frame_done = done_q;

endmodule

// File: tb/tb_board_status_uart.sv
// -----------------------------------------------------------------------------
// tb_board_status_uart
// Drives board_status_uart with small clock/baud parameters, decodes the UART
// line into text lines and compares them, plus frame timing, against values
// derived from the status flags the bench applied.
// -----------------------------------------------------------------------------
module tb_board_status_uart;
  localparam int CLK_FREQ      = 1000;
  localparam int BAUD          = 100;
  localparam int REPORT_PERIOD = 5000;
  localparam int CPB           = CLK_FREQ / BAUD;
  localparam int FRAME_CYCLES  = 190 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  board_status_uart_if bus ();

  board_status_uart #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .REPORT_PERIOD(REPORT_PERIOD)
  ) dut (
    .i_clk_25m(clk),
    .i_rst    (rst),
    .st       (bus)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  string lines_q[$];
  int    starts_q[$];
  int    fd_q[$];
  int    busy_len = 0;
  int    frame_err = 0;

  // Expected line from the applied flags.
  function automatic string exp_line(logic sd, logic ram, logic [3:0] key);
    return $sformatf("SD:%0d RAM:%0d K:%0d%0d%0d%0d\015\012",
                     sd, ram, ~key[3], ~key[2], ~key[1], ~key[0]);
  endfunction

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      if (c == 8'h0D)      r = {r, "<CR>"};
      else if (c == 8'h0A) r = {r, "<LF>"};
      else                 r = {r, $sformatf("%c", c)};
    end
    return r;
  endfunction

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(string tag, int obs, int lo, int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_str(string tag, string obs, string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(obs), vis(exp));
    end
  endtask

  task automatic wait_lines(int n, int budget);
    int w = 0;
    while (lines_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (lines_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout_frame%0d: observed %0d frames expected %0d", n, lines_q.size(), n);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "aborting: no frame within budget");
    end
  endtask

  // UART line decoder: samples each bit mid-period, assembles lines on LF.
  initial begin : decoder
    bit         active = 1'b0;
    int         cnt = 0;
    int         k = 0;
    logic [7:0] ch = '0;
    string      line = "";
    int         lstart = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        line   = "";
      end else if (!active) begin
        if (bus.o_uart_tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          if (line.len() == 0) lstart = cyc;
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2) begin
          if (bus.o_uart_tx !== 1'b0) begin
            frame_err++;
            active = 1'b0;
          end
        end else if (cnt > CPB / 2 && ((cnt - CPB / 2) % CPB) == 0) begin
          k = (cnt - CPB / 2) / CPB;
          if (k <= 8) begin
            ch[k-1] = bus.o_uart_tx;
          end else begin
            if (bus.o_uart_tx !== 1'b1) frame_err++;
            line = {line, $sformatf("%c", ch)};
            if (ch == 8'h0A) begin
              lines_q.push_back(line);
              starts_q.push_back(lstart);
              line = "";
            end
            active = 1'b0;
          end
        end
      end
    end
  end

  // Busy length and frame-done timestamps.
  initial begin : monitor
    int run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (bus.o_busy === 1'b1) begin
          run++;
        end else if (run != 0) begin
          busy_len = run;
          run = 0;
        end
        if (bus.o_frame_done === 1'b1) fd_q.push_back(cyc);
      end
    end
  end

  initial begin : stimulus
    logic       sd  = 1'b0;
    logic       ram = 1'b0;
    logic [3:0] key = 4'hF;
    int         c0  = 0;
    int         nl  = 0;

    bus.i_sd_init_done = sd;
    bus.i_sdram_error  = ram;
    bus.i_key          = key;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_int("reset_tx", bus.o_uart_tx, 1);
    check_int("reset_busy", bus.o_busy, 0);
    check_int("reset_frame_done", bus.o_frame_done, 0);

    // Boot frame
    rst = 1'b0;
    wait_lines(1, FRAME_CYCLES + 100);
    check_str("boot_text", lines_q[0], "SD:0 RAM:0 K:0000\015\012");
    repeat (20) @(negedge clk);
    check_int("boot_busy_len", busy_len, FRAME_CYCLES);
    check_int("boot_frame_done_count", fd_q.size(), 1);
    check_int("boot_framing", frame_err, 0);

    // Periodic frame
    wait_lines(2, REPORT_PERIOD + FRAME_CYCLES);
    check_str("period_text", lines_q[1], exp_line(1'b0, 1'b0, 4'hF));
    check_int("period_gap", starts_q[1] - starts_q[0], REPORT_PERIOD);

    // Keys: shown in the next periodic frame, no extra trigger
    key = 4'b0110;
    bus.i_key = key;
    wait_lines(3, REPORT_PERIOD + FRAME_CYCLES);
    check_str("keys_text", lines_q[2], exp_line(sd, ram, key));
    check_int("keys_no_trigger_gap", starts_q[2] - starts_q[1], REPORT_PERIOD);

    // Change event while idle, then ram change mid-frame
    repeat (20 + $urandom_range(0, 200)) @(negedge clk);
    sd = 1'b1;
    bus.i_sd_init_done = sd;
    c0 = cyc;
    repeat (500) @(negedge clk);
    check_int("midframe_busy", bus.o_busy, 1);
    ram = 1'b1;
    bus.i_sdram_error = ram;
    wait_lines(4, 2 * FRAME_CYCLES);
    check_range("change_latency", starts_q[3] - c0, 4, 5);
    check_str("snapshot_text", lines_q[3], exp_line(1'b1, 1'b0, key));

    // Collapse: three toggles during the follow-up frame
    repeat (50) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ram = ~ram;
      bus.i_sdram_error = ram;
      repeat (100) @(negedge clk);
    end
    wait_lines(5, 2 * FRAME_CYCLES);
    check_str("followup_text", lines_q[4], exp_line(1'b1, 1'b1, key));
    check_int("followup_gap", starts_q[4] - fd_q[3], 1);
    wait_lines(6, 2 * FRAME_CYCLES);
    check_str("collapse_text", lines_q[5], exp_line(sd, ram, key));
    check_int("collapse_gap", starts_q[5] - fd_q[4], 1);
    wait_lines(7, REPORT_PERIOD + FRAME_CYCLES);
    check_int("collapse_single_gap", starts_q[6] - starts_q[5], REPORT_PERIOD);
    check_str("collapse_period_text", lines_q[6], exp_line(sd, ram, key));
    repeat (20) @(negedge clk);
    check_int("period_busy_len", busy_len, FRAME_CYCLES);

    // Randomized change events with random keys
    for (int i = 0; i < 3; i++) begin
      repeat (20 + $urandom_range(0, 280)) @(negedge clk);
      sd  = ~sd;
      ram = 1'($urandom_range(0, 1));
      key = 4'($urandom);
      bus.i_sd_init_done = sd;
      bus.i_sdram_error  = ram;
      bus.i_key          = key;
      c0 = cyc;
      wait_lines(8 + i, 2 * FRAME_CYCLES);
      check_range($sformatf("rand%0d_latency", i), starts_q[7+i] - c0, 4, 5);
      check_str($sformatf("rand%0d_text", i), lines_q[7+i], exp_line(sd, ram, key));
    end

    // Reset in the middle of byte 7
    repeat (20) @(negedge clk);
    sd = ~sd;
    bus.i_sd_init_done = sd;
    repeat (10 + 75 * CPB) @(negedge clk);
    check_int("pre_reset_busy", bus.o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_int("rst_midframe_tx", bus.o_uart_tx, 1);
    check_int("rst_midframe_busy", bus.o_busy, 0);
    repeat (3) @(negedge clk);
    sd  = 1'($urandom_range(0, 1));
    ram = 1'($urandom_range(0, 1));
    key = 4'($urandom);
    bus.i_sd_init_done = sd;
    bus.i_sdram_error  = ram;
    bus.i_key          = key;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    nl = lines_q.size();
    wait_lines(nl + 1, FRAME_CYCLES + 100);
    check_str("post_reset_text", lines_q[nl], exp_line(sd, ram, key));
    repeat (20) @(negedge clk);
    check_int("post_reset_busy_len", busy_len, FRAME_CYCLES);
    check_int("framing_errors", frame_err, 0);
    check_int("frame_done_count", fd_q.size(), lines_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_status_uart.md
# board_status_uart

Board self-test status reporter for the XI050AB bring-up image. Runs in the `i_clk_25m` domain downstream of the TF-card and SDRAM test blocks. Samples their pass/fail flags and the four user keys, formats them as a fixed 19-byte ASCII line, and transmits it on a UART TX pin (8N1). Lines are sent at power-up, periodically, and whenever a status flag changes, so a PC terminal shows the board state without reading LEDs.

## Interface
- `CLK_FREQ`, 25_000_000: input clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. Bit period `CLKS_PER_BIT = CLK_FREQ/BAUD`, computed with truncating integer division (217 at the defaults). Must be ≥ 2.
- `REPORT_PERIOD`, 25_000_000: clock cycles between periodic frame starts.
- `i_clk_25m`, in, 1: the single clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_sd_init_done`, in, 1: TF-card init success. Asynchronous to this block.
- `i_sdram_error`, in, 1: SDRAM test error flag. Asynchronous to this block.
- `i_key`, in, 4: raw keys, active-low (0 = pressed). Asynchronous to this block.
- `o_uart_tx`, out, 1: serial output. Idle high.
- `o_busy`, out, 1: high while a frame is on the line.
- `o_frame_done`, out, 1: one-cycle pulse after the last stop bit of a frame.

## Operation
- **Synchronizers.** All six inputs pass through 2-flop synchronizers. A third register holds the previous synchronized `sd` and `ram` values.
- **Change event.** A change event fires when the synchronized `sd` or `ram` value differs from its previous value. Key changes never trigger a frame.
- **Triggers.** There are three triggers: a change event, the period timer reaching `REPORT_PERIOD-1`, and reset release. Reset sets `pending`=1, so one boot frame is sent.
- **Pending flag.** Any trigger sets `pending`. Triggers while `pending` is set or while a frame is busy collapse into a single pending frame. A trigger is never lost and never queued twice.
- **Period timer.** Clears to 0 in the cycle a frame starts. Otherwise it increments and saturates at `REPORT_PERIOD-1`.
- **Snapshot.** At frame start, the synchronized `sd`, `ram` and `key[3:0]` are latched. The whole frame uses this snapshot, so mid-frame input changes do not alter the text.
- **Frame content.** Bytes in order: `S`,`D`,`:`,d0,` `,`R`,`A`,`M`,`:`,d1,` `,`K`,`:`,k3,k2,k1,k0,CR(0x0D),LF(0x0A).
  - d0 = `'0'` + sd.
  - d1 = `'0'` + ram.
  - kN = `'0'` + ~key[N], so a pressed key shows `'1'`.
- **FSM states.**
  - IDLE: line high. Go to START when `pending`=1, clearing `pending`, loading the snapshot and setting byte index = 0.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then, if byte index = 18, go to IDLE and pulse `o_frame_done`; else increment the index and go to START.
- **Byte spacing.** Bytes are sent back to back with no idle gap between frame bytes.
- **Back-to-back frames.** If `pending` is set when a frame ends, the next frame's start bit begins one cycle after the IDLE cycle.

## Timing
- **Reset values.** `o_uart_tx`=1, `o_busy`=0, `o_frame_done`=0. Timer = 0, FSM = IDLE, `pending`=1.
- **Registered outputs.** All outputs are registered.
- **Frame start latency.** `pending` is observed in IDLE at edge T. The start bit appears on `o_uart_tx` and `o_busy` rises after edge T+1.
- **Input-to-start latency.** An async status edge produces a start bit 4–5 cycles after the input edge when the block is idle: 2 sync, 1 compare, 1 pending, 1 FSM.
- **Frame length.** Exactly 190×CLKS_PER_BIT cycles (41 230 at defaults). `o_busy` is high for exactly this many cycles.
- **Frame done.** `o_frame_done` is high in the first cycle `o_busy` is low after a frame.
- **Reset mid-frame.** The next edge forces the reset values, and the partial byte is abandoned. After release, a complete boot frame is sent from byte 0.
- **Simultaneous events.** A period expiry and a change event in the same cycle produce one frame. A trigger in the frame's last STOP cycle sets `pending` and produces the next frame.
- **Short period.** If `REPORT_PERIOD` ≤ the frame length, frames run continuously. This is legal.

## Test plan
Use bench parameters `CLK_FREQ`=1000, `BAUD`=100 (CLKS_PER_BIT=10), `REPORT_PERIOD`=5000.
- **Boot frame.** Release reset with sd=0, ram=0, keys=4'b1111 → bench UART decoder reads `"SD:0 RAM:0 K:0000\r\n"`. `o_busy` is high for exactly 1900 cycles. `o_frame_done` pulses once.
- **Period.** Hold inputs idle → the next frame's start bit occurs 5000 cycles after the previous frame's start bit. Contents are identical.
- **Change and snapshot.** Raise `i_sd_init_done` while idle → start bit within 5 cycles with text `"SD:1 RAM:0 …"`. Raise `i_sdram_error` mid-frame → the current frame still shows RAM:0, and the next frame starts one cycle after `o_frame_done` with RAM:1.
- **Collapse.** Toggle `i_sdram_error` three times during one frame → exactly one follow-up frame.
- **Keys.** Set `i_key`=4'b0110 → the next frame shows `K:1001`. No extra frame is triggered.
- **Reset mid-frame.** Assert `i_rst` at byte 7 → `o_uart_tx`=1 and `o_busy`=0 on the next edge. After release, a full 19-byte frame is decoded with no framing error.
